uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Control and buffering layer above the UART receiver.
- Gates the receiver enable and applies parity/prescale configuration only between frames, so a frame is never cut mid-reception.
- Collects completed frames into a small FIFO and presents them to a consumer on a valid/ready interface.
- Keeps sticky overrun status and saturating parity-error and stop-error counters for software.

Parameters:
- DATA_WIDTH, 8, frame payload width.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, 2 or more.
- PRESCALE_DEFAULT, 8, prescale value loaded at reset.
- TIMEOUT_CYCLES, 256, idle-timeout threshold; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- ctrl_enable  in  1  software receive enable.
- cfg_wr  in  1  one-cycle pulse; captures the cfg_* inputs into the shadow register.
- cfg_parity_en  in  1  requested parity enable.
- cfg_parity_type  in  1  requested parity type; 0 = even, 1 = odd.
- cfg_prescale  in  6  requested oversampling prescale.
- cfg_busy  out  1  a shadow configuration is pending and not yet applied.
- rx_en  out  1  receiver enable.
- rx_parity_en  out  1  applied parity enable.
- rx_parity_type  out  1  applied parity type.
- rx_prescale  out  6  applied prescale.
- rx_busy  in  1  receiver is inside a frame (its FSM is not IDLE).
- rx_data  in  DATA_WIDTH  received payload.
- rx_data_valid  in  1  one-cycle pulse when a frame completes.
- rx_parity_err  in  1  one-cycle pulse on a parity error.
- rx_stop_err  in  1  one-cycle pulse on a stop-bit error.
- m_data  out  DATA_WIDTH  FIFO head entry.
- m_valid  out  1  FIFO is non-empty.
- m_ready  in  1  consumer accepts the head entry.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- par_err_cnt  out  8  saturating parity-error count.
- stop_err_cnt  out  8  saturating stop-error count.
- err_clr  in  1  clears overrun, par_err_cnt and stop_err_cnt.
- rx_timeout  out  1  idle-timeout flag; see Optional Feature.

Behaviour:
- Reset values: state OFF; rx_en 0; rx_parity_en 0; rx_parity_type 0; rx_prescale PRESCALE_DEFAULT; cfg_busy 0; FIFO empty (m_valid 0, fifo_count 0); overrun 0; both counters 0; rx_timeout 0. A reset during a frame discards the FIFO contents and the pending configuration.
- Shadow configuration:
  - cfg_wr latches the cfg_* inputs and sets cfg_busy on the next cycle.
  - A second cfg_wr while a configuration is pending overwrites the shadow.
  - cfg_busy clears in the APPLY cycle.
- State machine (all outputs registered):
  - OFF, rx_en=0: go to APPLY if pending; else go to RUN if ctrl_enable.
  - RUN, rx_en=1: leave when ctrl_enable=0 or a configuration is pending.
    - If rx_busy=1, go to DRAIN.
    - Otherwise go to APPLY if pending, else OFF.
  - DRAIN, rx_en=1: hold until rx_busy=0, then go to APPLY if pending, else OFF. A frame that completes during DRAIN is still accepted.
  - APPLY, rx_en=0, lasts exactly 1 cycle: copy the shadow to the rx_* config outputs, clear cfg_busy, then go to RUN if ctrl_enable, else OFF.
  - The rx_* config outputs never change while rx_en=1.
- FIFO write:
  - Attempted on rx_data_valid in any state.
  - Accepted when the FIFO is not full, or when full with a pop in the same cycle.
  - Otherwise the frame is dropped and overrun is set.
- FIFO read:
  - First-word fall-through: m_data is valid while m_valid=1.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error handling:
  - rx_parity_err and rx_stop_err each increment their counter; counters saturate at 255.
  - If rx_data_valid coincides with either error pulse, the error is counted and the data is not written.
  - err_clr wins over a same-cycle increment or overrun event.
- Latency: rx_data_valid to m_valid is 1 cycle.

Optional Feature:
- Macro UART_RX_CTRL_TIMEOUT_EN.
- Defined:
  - An idle counter restarts on any accepted write, any pop, or while the FIFO is empty.
  - rx_timeout is set when the counter reaches TIMEOUT_CYCLES-1 with the FIFO non-empty.
  - rx_timeout holds until the next write, pop or reset.
- Undefined: no counter is built and rx_timeout is tied to 0.

Decomposition:
- Package uart_rx_ctrl_pkg holds:
  - the state enum (OFF, RUN, DRAIN, APPLY);
  - the cfg struct {parity_en, parity_type, prescale[5:0]};
  - the error-counter width constant (8) and its saturation value (255).
- Sub-module uart_rx_ctrl_fifo: synchronous FIFO with FWFT, count and full/empty outputs.

Test Plan:
- Reset, then ctrl_enable=1 -> rx_en=1 after 1 cycle; rx_prescale=8; cfg_busy=0.
- rx_busy=1, then cfg_wr (prescale=16, parity_en=1) -> DRAIN with rx_en=1 and cfg_busy=1. After rx_busy falls: 1 APPLY cycle with rx_en=0, rx_prescale=16; then RUN.
- 9 frames (0x01..0x09) with m_ready=0 and DEPTH=8 -> fifo_count=8, overrun=1, reads return 0x01..0x08.
- FIFO full; rx_data_valid with m_ready=1 in the same cycle -> count stays 8, no overrun, new byte stored last.
- 300 rx_parity_err pulses -> par_err_cnt=255. err_clr coinciding with an rx_stop_err pulse -> stop_err_cnt=0.
- With macro, one byte held and no traffic for 256 cycles -> rx_timeout=1; a pop clears it.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive control slice.
// Optional idle-timeout feature is selected with UART_RX_CTRL_TIMEOUT_EN.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  typedef struct packed {
    logic       parity_en;
    logic       parity_type;
    logic [5:0] prescale;
  } cfg_t;

  localparam int               ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module uart_rx_ctrl_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         push_acc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push_s, do_pop_s;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == {CW{1'b0}});
  assign do_pop_s   = pop_i & ~empty_o;
  assign do_push_s  = push_i & (~full_o | do_pop_s);
  assign push_acc_o = do_push_s;
  assign data_o     = mem_q[rptr_q];
  assign count_o    = count_q;

  // storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_push_s) wptr_q <= wptr_q + AW'(1);
      if (do_pop_s)  rptr_q <= rptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive control: enable gating, between-frame config apply, receive FIFO and
// error status. Define UART_RX_CTRL_TIMEOUT_EN to build the idle-timeout flag.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 8,
  parameter int PRESCALE_DEFAULT = 8,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ctrl_enable,
  input  logic                            cfg_wr,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_type,
  input  logic [5:0]                      cfg_prescale,
  output logic                            cfg_busy,
  output logic                            rx_en,
  output logic                            rx_parity_en,
  output logic                            rx_parity_type,
  output logic [5:0]                      rx_prescale,
  input  logic                            rx_busy,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  input  logic                            rx_data_valid,
  input  logic                            rx_parity_err,
  input  logic                            rx_stop_err,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun,
  output logic [7:0]                      par_err_cnt,
  output logic [7:0]                      stop_err_cnt,
  input  logic                            err_clr,
  output logic                            rx_timeout
);
  localparam cfg_t CFG_RESET = '{parity_en: 1'b0, parity_type: 1'b0,
                                 prescale: 6'(PRESCALE_DEFAULT)};

  state_e                 state_q;
  cfg_t                   shadow_q, rx_cfg_q;
  logic                   cfg_busy_q, rx_en_q, overrun_q;
  logic [ERR_CNT_W-1:0]   par_cnt_q, stop_cnt_q;
  logic                   wr_try_s, wr_acc_s, pop_s, full_s, empty_s;

  // frames flagged with any error are counted but never stored
  assign wr_try_s = rx_data_valid & ~rx_parity_err & ~rx_stop_err;
  assign pop_s    = ~empty_s & m_ready;

  uart_rx_ctrl_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_try_s),
    .pop_i      (pop_s),
    .data_i     (rx_data),
    .data_o     (m_data),
    .count_o    (fifo_count),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .push_acc_o (wr_acc_s)
  );

  // control FSM; the applied config only changes on entry to APPLY (rx_en=0)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      rx_en_q    <= 1'b0;
      cfg_busy_q <= 1'b0;
      shadow_q   <= CFG_RESET;
      rx_cfg_q   <= CFG_RESET;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (cfg_busy_q) begin
            state_q <= ST_APPLY; rx_en_q <= 1'b0; rx_cfg_q <= shadow_q; cfg_busy_q <= 1'b0;
          end else if (ctrl_enable) begin
            state_q <= ST_RUN; rx_en_q <= 1'b1;
          end else begin
            state_q <= ST_OFF; rx_en_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!ctrl_enable || cfg_busy_q) begin
            if (rx_busy) begin
              state_q <= ST_DRAIN; rx_en_q <= 1'b1;
            end else if (cfg_busy_q) begin
              state_q <= ST_APPLY; rx_en_q <= 1'b0; rx_cfg_q <= shadow_q; cfg_busy_q <= 1'b0;
            end else begin
              state_q <= ST_OFF; rx_en_q <= 1'b0;
            end
          end else begin
            state_q <= ST_RUN; rx_en_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (rx_busy) begin
            state_q <= ST_DRAIN; rx_en_q <= 1'b1;
          end else if (cfg_busy_q) begin
            state_q <= ST_APPLY; rx_en_q <= 1'b0; rx_cfg_q <= shadow_q; cfg_busy_q <= 1'b0;
          end else begin
            state_q <= ST_OFF; rx_en_q <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (ctrl_enable) begin
            state_q <= ST_RUN; rx_en_q <= 1'b1;
          end else begin
            state_q <= ST_OFF; rx_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_OFF; rx_en_q <= 1'b0;
        end
      endcase
      if (cfg_wr) begin
        shadow_q   <= '{parity_en: cfg_parity_en, parity_type: cfg_parity_type,
                        prescale: cfg_prescale};
        cfg_busy_q <= 1'b1;
      end
    end
  end

  // sticky overrun and saturating error counters; err_clr has priority
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      overrun_q  <= 1'b0;
      par_cnt_q  <= {ERR_CNT_W{1'b0}};
      stop_cnt_q <= {ERR_CNT_W{1'b0}};
    end else begin
      if (wr_try_s && !wr_acc_s)                    overrun_q  <= 1'b1;
      if (rx_parity_err && par_cnt_q != ERR_CNT_MAX) par_cnt_q  <= par_cnt_q + ERR_CNT_W'(1);
      if (rx_stop_err && stop_cnt_q != ERR_CNT_MAX)  stop_cnt_q <= stop_cnt_q + ERR_CNT_W'(1);
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_q;
  logic          timeout_q;

  // idle timer runs only while data sits unread with no FIFO activity
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q    <= {TW{1'b0}};
      timeout_q <= 1'b0;
    end else if (wr_acc_s || pop_s || empty_s) begin
      idle_q    <= {TW{1'b0}};
      timeout_q <= 1'b0;
    end else if (idle_q == IDLE_MAX) begin
      idle_q    <= idle_q;
      timeout_q <= 1'b1;
    end else begin
      idle_q    <= idle_q + TW'(1);
      timeout_q <= timeout_q;
    end
  end

  assign rx_timeout = timeout_q;
`else
  assign rx_timeout = 1'b0;
`endif

  assign cfg_busy       = cfg_busy_q;
  assign rx_en          = rx_en_q;
  assign rx_parity_en   = rx_cfg_q.parity_en;
  assign rx_parity_type = rx_cfg_q.parity_type;
  assign rx_prescale    = rx_cfg_q.prescale;
  assign m_valid        = ~empty_s;
  assign overrun        = overrun_q;
  assign par_err_cnt    = par_cnt_q;
  assign stop_err_cnt   = stop_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a queue-based FIFO scoreboard.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst, ctrl_enable, cfg_wr, cfg_parity_en, cfg_parity_type;
  logic [5:0] cfg_prescale, rx_prescale;
  logic       cfg_busy, rx_en, rx_parity_en, rx_parity_type;
  logic       rx_busy, rx_data_valid, rx_parity_err, rx_stop_err;
  logic [7:0] rx_data, m_data, par_err_cnt, stop_err_cnt;
  logic       m_valid, m_ready, overrun, err_clr, rx_timeout;
  logic [3:0] fifo_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .cfg_wr(cfg_wr),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
    .cfg_prescale(cfg_prescale), .cfg_busy(cfg_busy), .rx_en(rx_en),
    .rx_parity_en(rx_parity_en), .rx_parity_type(rx_parity_type),
    .rx_prescale(rx_prescale), .rx_busy(rx_busy), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_parity_err(rx_parity_err),
    .rx_stop_err(rx_stop_err), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .fifo_count(fifo_count), .overrun(overrun),
    .par_err_cnt(par_err_cnt), .stop_err_cnt(stop_err_cnt),
    .err_clr(err_clr), .rx_timeout(rx_timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one valid frame; the scoreboard takes it only if the model FIFO has room
  task automatic send_frame(input logic [7:0] d);
    rx_data = d; rx_data_valid = 1'b1;
    if (exp_q.size() < 8) exp_q.push_back(d);
    tick;
    rx_data_valid = 1'b0;
  endtask

  task automatic drain_fifo(input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < 20 && m_valid; i++) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s_extra: got data %0h expected none", tag, m_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (m_data !== exp_v) begin
          n_fail++; $display("FAIL %s_data: got %0h expected %0h", tag, m_data, exp_v);
        end
      end
      tick;
    end
    m_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL %s_empty: got count %0d expected 0 (left %0d)", tag, fifo_count, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    n_checks++;
    if ({rx_en, cfg_busy, m_valid, overrun, rx_timeout, rx_parity_en, rx_parity_type} !== 7'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000",
        {rx_en, cfg_busy, m_valid, overrun, rx_timeout, rx_parity_en, rx_parity_type});
    end
    n_checks++;
    if (rx_prescale !== 6'd8 || fifo_count !== 4'd0 || par_err_cnt !== 8'd0 || stop_err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_values: got prescale %0d count %0d par %0d stop %0d expected 8 0 0 0",
        rx_prescale, fifo_count, par_err_cnt, stop_err_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_enable;
    ctrl_enable = 1'b1; tick;
    n_checks++;
    if (rx_en !== 1'b1 || rx_prescale !== 6'd8 || cfg_busy !== 1'b0) begin
      n_fail++; $display("FAIL enable: got en %b prescale %0d busy %b expected 1 8 0", rx_en, rx_prescale, cfg_busy);
    end
  endtask

  task automatic test_drain_apply;
    rx_busy = 1'b1;
    cfg_prescale = 6'd16; cfg_parity_en = 1'b1; cfg_parity_type = 1'b0; cfg_wr = 1'b1;
    tick;
    cfg_wr = 1'b0;
    n_checks++;
    if (cfg_busy !== 1'b1 || rx_prescale !== 6'd8) begin
      n_fail++; $display("FAIL cfg_latch: got busy %b prescale %0d expected 1 8", cfg_busy, rx_prescale);
    end
    tick;
    n_checks++;
    if (rx_en !== 1'b1 || cfg_busy !== 1'b1 || rx_prescale !== 6'd8) begin
      n_fail++; $display("FAIL drain_entry: got en %b busy %b prescale %0d expected 1 1 8", rx_en, cfg_busy, rx_prescale);
    end
    send_frame(8'hA5);
    n_checks++;
    if (rx_en !== 1'b1 || m_valid !== 1'b1 || fifo_count !== 4'd1) begin
      n_fail++; $display("FAIL drain_frame: got en %b valid %b count %0d expected 1 1 1", rx_en, m_valid, fifo_count);
    end
    rx_busy = 1'b0; tick;
    n_checks++;
    if (rx_en !== 1'b0 || rx_prescale !== 6'd16 || rx_parity_en !== 1'b1 || cfg_busy !== 1'b0) begin
      n_fail++; $display("FAIL apply: got en %b prescale %0d par_en %b busy %b expected 0 16 1 0",
        rx_en, rx_prescale, rx_parity_en, cfg_busy);
    end
    tick;
    n_checks++;
    if (rx_en !== 1'b1 || rx_prescale !== 6'd16) begin
      n_fail++; $display("FAIL apply_to_run: got en %b prescale %0d expected 1 16", rx_en, rx_prescale);
    end
    ctrl_enable = 1'b0; tick;
    n_checks++;
    if (rx_en !== 1'b0) begin
      n_fail++; $display("FAIL run_to_off: got en %b expected 0", rx_en);
    end
    ctrl_enable = 1'b1; tick;
    n_checks++;
    if (rx_en !== 1'b1 || rx_prescale !== 6'd16) begin
      n_fail++; $display("FAIL off_to_run: got en %b prescale %0d expected 1 16", rx_en, rx_prescale);
    end
    drain_fifo("drain");
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i));
      n_checks++;
      if (fifo_count !== 4'(exp_q.size()) || m_valid !== 1'b1) begin
        n_fail++; $display("FAIL ovr_count_%0d: got %0d valid %b expected %0d 1", i, fifo_count, m_valid, exp_q.size());
      end
    end
    n_checks++;
    if (overrun !== 1'b1 || fifo_count !== 4'd8) begin
      n_fail++; $display("FAIL overrun_set: got overrun %b count %0d expected 1 8", overrun, fifo_count);
    end
    drain_fifo("ovr");
    err_clr = 1'b1; tick; err_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clr: got %b expected 0", overrun);
    end
  endtask

  task automatic test_full_pushpop;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i));
    // err_clr must win over an overrun event in the same cycle
    err_clr = 1'b1; rx_data = 8'hEE; rx_data_valid = 1'b1; tick;
    err_clr = 1'b0; rx_data_valid = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || fifo_count !== 4'd8) begin
      n_fail++; $display("FAIL clr_vs_overrun: got overrun %b count %0d expected 0 8", overrun, fifo_count);
    end
    n_checks++;
    exp_v = exp_q.pop_front();
    if (m_data !== exp_v) begin
      n_fail++; $display("FAIL full_head: got %0h expected %0h", m_data, exp_v);
    end
    m_ready = 1'b1; rx_data = 8'h5A; rx_data_valid = 1'b1; exp_q.push_back(8'h5A);
    tick;
    m_ready = 1'b0; rx_data_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 4'd8 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL full_pushpop: got count %0d overrun %b expected 8 0", fifo_count, overrun);
    end
    drain_fifo("pushpop");
  endtask

  task automatic test_errors;
    rx_data = 8'h77; rx_data_valid = 1'b1; rx_parity_err = 1'b1; tick;
    rx_data_valid = 1'b0; rx_parity_err = 1'b0;
    n_checks++;
    if (fifo_count !== 4'd0 || par_err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL par_drop: got count %0d par %0d expected 0 1", fifo_count, par_err_cnt);
    end
    rx_data_valid = 1'b1; rx_stop_err = 1'b1; tick;
    rx_data_valid = 1'b0; rx_stop_err = 1'b0;
    n_checks++;
    if (fifo_count !== 4'd0 || stop_err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL stop_drop: got count %0d stop %0d expected 0 1", fifo_count, stop_err_cnt);
    end
    rx_parity_err = 1'b1;
    for (int i = 0; i < 300; i++) tick;
    rx_parity_err = 1'b0;
    n_checks++;
    if (par_err_cnt !== 8'd255) begin
      n_fail++; $display("FAIL par_saturate: got %0d expected 255", par_err_cnt);
    end
    err_clr = 1'b1; rx_stop_err = 1'b1; tick;
    err_clr = 1'b0; rx_stop_err = 1'b0;
    n_checks++;
    if (stop_err_cnt !== 8'd0 || par_err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clr_vs_incr: got stop %0d par %0d expected 0 0", stop_err_cnt, par_err_cnt);
    end
    rx_stop_err = 1'b1; tick; rx_stop_err = 1'b0;
    n_checks++;
    if (stop_err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL stop_after_clr: got %0d expected 1", stop_err_cnt);
    end
  endtask

  task automatic test_timeout;
    int n;
    send_frame(8'h3C);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      tick;
      if (rx_timeout === 1'b1 && n == 0) n = i;
    end
`ifdef UART_RX_CTRL_TIMEOUT_EN
    n_checks++;
    if (n != 256) begin
      n_fail++; $display("FAIL timeout_set: got cycle %0d expected 256", n);
    end
    m_ready = 1'b1; exp_v = exp_q.pop_front(); tick; m_ready = 1'b0;
    n_checks++;
    if (rx_timeout !== 1'b0 || fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL timeout_clr: got %b count %0d expected 0 0", rx_timeout, fifo_count);
    end
`else
    n_checks++;
    if (n != 0) begin
      n_fail++; $display("FAIL timeout_off: got flag at cycle %0d expected never", n);
    end
    drain_fifo("tmo");
`endif
  endtask

  initial begin
    rst = 1'b1; ctrl_enable = 1'b0; cfg_wr = 1'b0; cfg_parity_en = 1'b0;
    cfg_parity_type = 1'b0; cfg_prescale = 6'd0; rx_busy = 1'b0; rx_data = 8'd0;
    rx_data_valid = 1'b0; rx_parity_err = 1'b0; rx_stop_err = 1'b0;
    m_ready = 1'b0; err_clr = 1'b0;
    test_reset;
    test_enable;
    test_drain_apply;
    test_overrun;
    test_full_pushpop;
    test_errors;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
